// File: rtl/alu_exec_unit_if.sv
// Bundle of execute-stage operands, controls and results shared by alu_exec_unit and its driver.
// The master side drives operands/controls; the slave side (the ALU) drives results and flags.
interface alu_exec_unit_if;
  logic [2:0]  aluop;
  logic [3:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [31:0] offset;
  logic        flag_we;
  logic [3:0]  gout;
  logic [31:0] result;
  logic        zout;
  logic        zflag;
  logic        nflag;
  logic        vflag;
  logic [31:0] pc_plus1;
  logic [31:0] branch_target;
  logic [2:0]  status_q;

  modport master (
    output aluop, funct, a, b, pc, offset, flag_we,
    input  gout, result, zout, zflag, nflag, vflag, pc_plus1, branch_target, status_q
  );

  modport slave (
    input  aluop, funct, a, b, pc, offset, flag_we,
    output gout, result, zout, zflag, nflag, vflag, pc_plus1, branch_target, status_q
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: control decode, 32-bit ALU with N/Z/V flags, PC+1 and branch-target adders.
// Define ALU_STATUS_REG_EN to build the clocked {N,Z,V} debug status register.
module alu_exec_unit (
  input logic           clk,
  input logic           rst_n,
  alu_exec_unit_if.slave bus
);

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluNor  = 4'b1100;
  localparam logic [3:0] AluNand = 4'b1101;

  logic [3:0]  gout;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        v_add;
  logic        v_sub;
  logic [31:0] result;
  logic        vflag;
  logic        zflag;

  always_comb begin
    gout = AluAdd;
    case (bus.aluop)
      3'b000: gout = AluAdd;
      3'b001: gout = AluSub;
      3'b010: begin
        case (bus.funct)
          4'b0000: gout = AluAdd;
          4'b0010: gout = AluSub;
          4'b0100: gout = AluAnd;
          4'b0101: gout = AluOr;
          4'b0110: gout = AluXor;
          4'b0111: gout = AluNor;
          4'b1010: gout = AluSlt;
          default: gout = AluAdd;
        endcase
      end
      3'b011: gout = AluOr;
      3'b100: gout = AluNand;
      default: gout = AluAdd;
    endcase
  end

  assign sum   = bus.a + bus.b;
  assign diff  = bus.a - bus.b;
  assign v_add = (bus.a[31] == bus.b[31]) & (sum[31] ^ bus.a[31]);
  assign v_sub = (bus.a[31] ^ bus.b[31]) & (diff[31] ^ bus.a[31]);

  always_comb begin
    result = 32'h0;
    vflag  = 1'b0;
    case (gout)
      AluAnd:  result = bus.a & bus.b;
      AluOr:   result = bus.a | bus.b;
      AluAdd: begin
        result = sum;
        vflag  = v_add;
      end
      AluSub: begin
        result = diff;
        vflag  = v_sub;
      end
      // Sign of a-b corrected by overflow gives the true signed less-than.
      AluSlt:  result = {31'h0, diff[31] ^ v_sub};
      AluXor:  result = bus.a ^ bus.b;
      AluNor:  result = ~(bus.a | bus.b);
      AluNand: result = ~(bus.a & bus.b);
      default: result = 32'h0;
    endcase
  end

  assign zflag             = (result == 32'h0);
  assign bus.gout          = gout;
  assign bus.result        = result;
  assign bus.zflag         = zflag;
  assign bus.zout          = zflag;
  assign bus.nflag         = result[31];
  assign bus.vflag         = vflag;
  assign bus.pc_plus1      = bus.pc + 32'h1;
  assign bus.branch_target = bus.pc + 32'h1 + bus.offset;

`ifdef ALU_STATUS_REG_EN
  logic [2:0] status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 3'b000;
    end else if (bus.flag_we) begin
      status_q <= {result[31], zflag, vflag};
    end
  end

  assign bus.status_q = status_q;
`else
  logic unused_status_in;
  assign unused_status_in = ^{clk, rst_n, bus.flag_we};
  assign bus.status_q     = 3'b000;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_exec_unit;

`ifdef ALU_STATUS_REG_EN
  localparam bit StatusEn = 1'b1;
`else
  localparam bit StatusEn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  bit   cmp_en;
  int   checks;
  int   errors;
  logic [2:0] exp_status;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] m_gout(logic [2:0] op, logic [3:0] fn);
    if (op == 3'd1) return 4'b0110;
    if (op == 3'd3) return 4'b0001;
    if (op == 3'd4) return 4'b1101;
    if (op != 3'd2) return 4'b0010;
    case (fn)
      4'd2:    return 4'b0110;
      4'd4:    return 4'b0000;
      4'd5:    return 4'b0001;
      4'd6:    return 4'b0011;
      4'd7:    return 4'b1100;
      4'd10:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [31:0] m_result(logic [3:0] g, logic [31:0] x, logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    case (g)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return (sx < sy) ? 32'd1 : 32'd0;
      4'b0011: return x ^ y;
      4'b1100: return ~(x | y);
      4'b1101: return ~(x & y);
      default: return 32'd0;
    endcase
  endfunction

  // Overflow = exact signed result does not fit in 32 bits.
  function automatic logic m_ovf(logic [3:0] g, logic [31:0] x, logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint s;
    if (g == 4'b0010) s = sx + sy;
    else if (g == 4'b0110) s = sx - sy;
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic logic [2:0] m_flags(logic [2:0] op, logic [3:0] fn, logic [31:0] x,
                                         logic [31:0] y);
    logic [3:0]  g = m_gout(op, fn);
    logic [31:0] r = m_result(g, x, y);
    return {r[31], r == 32'd0, m_ovf(g, x, y)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_status <= 3'b000;
    else if (bus.flag_we) exp_status <= m_flags(bus.aluop, bus.funct, bus.a, bus.b);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0]  g;
      logic [31:0] r;
      g = m_gout(bus.aluop, bus.funct);
      r = m_result(g, bus.a, bus.b);
      chk("gout", {28'd0, bus.gout}, {28'd0, g});
      chk("result", bus.result, r);
      chk("zflag", {31'd0, bus.zflag}, {31'd0, r == 32'd0});
      chk("zout", {31'd0, bus.zout}, {31'd0, r == 32'd0});
      chk("nflag", {31'd0, bus.nflag}, {31'd0, r[31]});
      chk("vflag", {31'd0, bus.vflag}, {31'd0, m_ovf(g, bus.a, bus.b)});
      chk("pc_plus1", bus.pc_plus1, bus.pc + 32'd1);
      chk("branch_target", bus.branch_target, bus.pc + bus.offset + 32'd1);
      chk("status_q", {29'd0, bus.status_q}, {29'd0, StatusEn ? exp_status : 3'b000});
    end
  end

  task automatic apply(input logic [2:0] op, input logic [3:0] fn, input logic [31:0] x,
                       input logic [31:0] y);
    bus.aluop = op;
    bus.funct = fn;
    bus.a     = x;
    bus.b     = y;
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h0;
      4:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] fn_tab [8];
    fn_tab = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd10};
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    bus.aluop = '0; bus.funct = '0; bus.a = '0; bus.b = '0;
    bus.pc = '0; bus.offset = '0; bus.flag_we = 1'b0;
    #2;
    chk("reset_status", {29'd0, bus.status_q}, 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    apply(3'b010, 4'b0000, 32'd7, 32'd5);
    chk("add_gout", {28'd0, bus.gout}, 32'h2);
    chk("add_result", bus.result, 32'd12);
    chk("add_flags", {29'd0, bus.nflag, bus.zflag, bus.vflag}, 32'd0);

    apply(3'b001, 4'b0000, 32'h1234, 32'h1234);
    chk("sub_zero", bus.result, 32'd0);
    chk("sub_zout", {30'd0, bus.zout, bus.zflag}, 32'd3);

    bus.flag_we = 1'b1;
    apply(3'b000, 4'b0000, 32'h7FFFFFFF, 32'd1);
    chk("ovf_result", bus.result, 32'h80000000);
    chk("ovf_nv", {30'd0, bus.nflag, bus.vflag}, 32'd3);
    @(posedge clk); #1;
    bus.flag_we = 1'b0;
    chk("status_capture", {29'd0, bus.status_q}, StatusEn ? 32'd5 : 32'd0);

    apply(3'b010, 4'b1010, 32'h80000000, 32'd1);
    chk("slt_ovf", bus.result, 32'd1);
    apply(3'b100, 4'b0000, 32'hF0F0F0F0, 32'hFFFF0000);
    chk("nand", bus.result, 32'h0F0FFFFF);

    bus.pc = 32'h5; bus.offset = 32'hFFFFFFFD; #1;
    chk("pc_plus1", bus.pc_plus1, 32'd6);
    chk("branch_target", bus.branch_target, 32'd3);
    bus.pc = 32'hFFFFFFFF; #1;
    chk("pc_wrap", bus.pc_plus1, 32'd0);

    @(posedge clk); #1;
    chk("status_hold", {29'd0, bus.status_q}, StatusEn ? 32'd5 : 32'd0);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", {29'd0, bus.status_q}, 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post_reset_hold", {29'd0, bus.status_q}, 32'd0);

    repeat (400) begin
      @(posedge clk); #1;
      bus.aluop   = 3'($urandom_range(0, 7));
      bus.funct   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : fn_tab[$urandom_range(0, 7)];
      bus.a       = pick_operand();
      bus.b       = ($urandom_range(0, 5) == 0) ? bus.a : pick_operand();
      bus.pc      = pick_operand();
      bus.offset  = pick_operand();
      bus.flag_we = 1'($urandom);
    end

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
